// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Bit-serial frame transmitter. Takes a parallel word over a valid/ready
//   handshake and emits, one bit per clock on a registered output:
//   PREAMBLE_LEN ones, the DATA_W payload bits LSB-first, then one guard 0.
//
//   Build option: define SERIAL_FRAME_TX_PARITY_EN to insert a one-cycle
//   even-parity bit (XOR of the payload) between the data and the guard bit.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   producer has a word on in_data
//   in_ready  out  word can be accepted this cycle (IDLE or GUARD)
//   in_data   in   [DATA_W-1:0] payload, sampled only on acceptance
//   out       out  serial bit stream (registered)
//   busy      out  frame in progress (state other than IDLE)
//   done      out  one-cycle pulse while the guard bit is on out
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int PREAMBLE_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_LEN = (DATA_W > PREAMBLE_LEN) ? DATA_W : PREAMBLE_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PAR   = 3'd4,
`endif
        GUARD = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                out_q, out_d;
    logic                done_q, done_d;
    logic                accept;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign in_ready = (state_q == IDLE) || (state_q == GUARD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign out      = out_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = shreg_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = PRE;
                    shreg_d = in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            PRE: begin
                if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = GUARD;
`endif
                    cnt_d   = '0;
                end else begin
                    shreg_d = shreg_q >> 1;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PAR: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
`endif
            GUARD: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = PRE;
                    shreg_d = in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // out and done are registered versions of the value belonging to the
        // state being entered, so they line up with state_q on the next cycle.
        // Entering DATA leaves shreg unshifted, so shreg_d[0] is always the
        // bit for the upcoming data cycle.
        case (state_d)
            PRE:     out_d = 1'b1;
            DATA:    out_d = shreg_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PAR:     out_d = par_q;
`endif
            default: out_d = 1'b0;
        endcase
        done_d = (state_d == GUARD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Directed bench for serial_frame_tx with default parameters (DATA_W=8,
//   PREAMBLE_LEN=2). Expected bit sequences are written out by hand, with the
//   first bit of each vector (its MSB) belonging to the cycle after acceptance.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    serial_frame_tx #(
        .DATA_W       (8),
        .PREAMBLE_LEN (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check n cycles of out/done/in_ready (busy must be 1 throughout),
    // stepping after each cycle. Bit n-1 of each vector is the first cycle.
    task automatic expect_seq(input string tag, input logic [31:0] ov,
                              input logic [31:0] dv, input logic [31:0] rv,
                              input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s out c%0d", tag, i), {31'd0, out}, {31'd0, ov[n-1-i]});
            check_eq($sformatf("%s done c%0d", tag, i), {31'd0, done}, {31'd0, dv[n-1-i]});
            check_eq($sformatf("%s rdy c%0d", tag, i), {31'd0, in_ready}, {31'd0, rv[n-1-i]});
            check_eq($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, 32'd1);
            step();
        end
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, " idle out"}, {31'd0, out}, 32'd0);
        check_eq({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " idle done"}, {31'd0, done}, 32'd0);
        check_eq({tag, " idle rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state held for 10 cycles with no traffic.
        for (int i = 0; i < 10; i++) begin
            expect_idle($sformatf("rst c%0d", i));
            step();
        end

`ifndef SERIAL_FRAME_TX_PARITY_EN
        // Single frame 8'hA5.
        accept_word(8'hA5);
        expect_seq("a5", 32'b11101001010, 32'b00000000001, 32'b00000000001, 11);
        expect_idle("a5");
        step();

        // Streaming: FF then 00 with in_valid held high, no idle gap.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_data  = 8'h00;
        expect_seq("ff", 32'b11111111110, 32'b00000000001, 32'b00000000001, 11);
        in_valid = 1'b0;
        expect_seq("00", 32'b11000000000, 32'b00000000001, 32'b00000000001, 11);
        expect_idle("stream");
        step();

        // in_data changes and in_valid drops mid-frame: payload stays 8'h3C.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        expect_seq("3c pre", 32'b11, 32'b00, 32'b00, 2);
        in_data  = 8'hC3;
        in_valid = 1'b0;
        expect_seq("3c dat", 32'b001111000, 32'b000000001, 32'b000000001, 9);
        expect_idle("3c");
        step();

        // Asynchronous reset in the middle of the data phase.
        accept_word(8'hFF);
        expect_seq("abort", 32'b1111, 32'b0000, 32'b0000, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort async out", {31'd0, out}, 32'd0);
        check_eq("abort async busy", {31'd0, busy}, 32'd0);
        check_eq("abort async done", {31'd0, done}, 32'd0);
        step();
        step();
        check_eq("abort held done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();
        expect_idle("abort post");
        accept_word(8'h01);
        expect_seq("01", 32'b11100000000, 32'b00000000001, 32'b00000000001, 11);
        expect_idle("01");
`else
        // Parity build: A5 has even weight (parity 0), 07 has odd weight.
        accept_word(8'hA5);
        expect_seq("pa5", 32'b111010010100, 32'b000000000001, 32'b000000000001, 12);
        expect_idle("pa5");
        step();
        accept_word(8'h07);
        expect_seq("p07", 32'b111110000010, 32'b000000000001, 32'b000000000001, 12);
        expect_idle("p07");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Bit-serial frame transmitter. It is the sending end for the team's single-bit sequence/marker detectors.
- Accepts a parallel word over a valid/ready handshake. Emits a serial frame on one output bit, one bit per clock: preamble of 1s, data LSB-first, then one guard 0.
- Sits between a word-level producer and a serial link whose receiver is a small sequence-detecting FSM.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PREAMBLE_LEN, 2, number of leading 1 bits per frame (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  payload word; sampled only on acceptance.
- out  output  1  serial bit stream, registered.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse in the cycle the guard bit is on out.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n); assertion takes effect immediately.
- Reset values: out=0, busy=0, done=0, state=IDLE, shift register=0, bit counter=0.
- Acceptance: a word is accepted when in_valid && in_ready at a rising clk edge. in_data is latched into the shift register at that edge.
- in_ready is combinational from state: 1 in IDLE and in GUARD, 0 in PRE, DATA and PAR.
- States and transitions:
  - IDLE: out=0. On accept -> PRE, counter=0.
  - PRE: out=1 for PREAMBLE_LEN cycles. On the last preamble cycle -> DATA, counter=0.
  - DATA: out=shift_reg[0], shifting right each cycle, for DATA_W cycles. After the last data bit -> GUARD, or -> PAR when the feature is enabled.
  - PAR: see Optional Feature.
  - GUARD: out=0 for exactly 1 cycle, done=1. On accept -> PRE (back-to-back frame); otherwise -> IDLE.
- Latency: the first preamble bit appears on out in the cycle after the accepting edge.
- Frame length: PREAMBLE_LEN+DATA_W+1 cycles (+1 with the feature). Back-to-back frames are separated by exactly one 0 bit (the guard).
- out is driven from a flop. No combinational path from in_* to out.
- Counter width: $clog2(max(DATA_W,PREAMBLE_LEN)+1). The counter resets to 0 on every state change, so it never wraps within a state.
- in_valid held high continuously: frames stream with a 1-cycle guard gap and no IDLE cycles.
- in_valid dropped mid-frame: no effect; the frame completes from latched data.
- in_data changing mid-frame: ignored.
- Reset mid-frame: frame aborted, out=0 immediately, latched data discarded, no done pulse.
- Unreachable state encodings: return to IDLE with out=0.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: PAR state inserted between DATA and GUARD. out = even-parity bit (XOR of all DATA_W latched bits) for 1 cycle. Frame length becomes PREAMBLE_LEN+DATA_W+2. in_ready is 0 in PAR.
- Undefined: no PAR state and no parity logic; DATA goes directly to GUARD.

Test Plan:
- Reset, in_valid=0 for 10 cycles -> out=0, busy=0, done=0, in_ready=1 throughout.
- Defaults, accept in_data=8'hA5 at edge 0 -> out on cycles 1..11 = 1,1,1,0,1,0,0,1,0,1,0; done=1 only on cycle 11; in_ready=0 on cycles 1..10.
- in_valid held high with words 8'hFF then 8'h00 -> out = 1,1,(1 x8),0,1,1,(0 x8),0. Second frame starts the cycle after the first guard with no idle cycle; done pulses twice.
- Accept 8'h3C; change in_data to 8'hC3 and drop in_valid on cycle 3 -> serialized data is still 0,0,1,1,1,1,0,0 (from 8'h3C).
- Accept 8'hFF; assert rst_n=0 asynchronously mid-DATA on cycle 5 -> out=0 before the next edge, busy=0, no done pulse. After release, a new accept of 8'h01 produces a clean frame 1,1,1,0,0,0,0,0,0,0,0.
- With SERIAL_FRAME_TX_PARITY_EN: 8'hA5 -> parity bit 0 on cycle 11, guard on cycle 12. 8'h07 -> parity bit 1; done moves to cycle 12.
